// File: rtl/i4001_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM store among N_REQ requesters; one access in flight.
// Define I4001_ARB_FIXED_PRI_EN for fixed priority (lowest index wins) instead of round-robin.
module i4001_rom_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1,
    parameter int IDW     = 3
) (
    input  logic                    sysclk,
    input  logic                    poc,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       rd_data,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic                    busy,
    output logic [IDW-1:0]          gnt_id
);

    localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [N_REQ-1:0]    ack_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                busy_q;
    logic [IDW-1:0]      gnt_id_q;

    logic                win_vld_d;
    logic [IDW-1:0]      win_id_d;
    logic [ADDR_W-1:0]   win_addr_d;
    logic [N_REQ-1:0]    ack_onehot_d;
    logic [IDW-1:0]      lo_id_d;

`ifndef I4001_ARB_FIXED_PRI_EN
    logic [IDW-1:0]      rr_ptr_q;
    logic [IDW-1:0]      rr_next_d;
    logic [IDW-1:0]      hi_id_d;
    logic                hi_vld_d;
`endif

    // Winner selection. Round-robin is done as two scans: the lowest requester at or
    // above rr_ptr wins, otherwise the lowest requester overall (wrap-around).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win_vld_d = 1'b0;
        lo_id_d   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld_d = 1'b1;
                lo_id_d   = IDW'(i);
            end
        end
`ifdef I4001_ARB_FIXED_PRI_EN
        win_id_d = lo_id_d;
`else
        hi_vld_d = 1'b0;
        hi_id_d  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(rr_ptr_q))) begin
                hi_vld_d = 1'b1;
                hi_id_d  = IDW'(i);
            end
        end
        win_id_d = hi_vld_d ? hi_id_d : lo_id_d;
`endif
    end

    always_comb begin
        win_addr_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id_d == IDW'(i)) begin
                win_addr_d = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        ack_onehot_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack_onehot_d[i] = (gnt_id_q == IDW'(i));
        end
    end

`ifndef I4001_ARB_FIXED_PRI_EN
    assign rr_next_d = (gnt_id_q == IDW'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
`endif

    always_ff @(posedge sysclk) begin
        if (poc) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ack_q      <= '0;
            rd_data_q  <= '0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            gnt_id_q   <= '0;
`ifndef I4001_ARB_FIXED_PRI_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register sees the pre-edge value of every other register.
            case (state_q)
                ST_IDLE: begin
                    if (win_vld_d) begin
                        gnt_id_q   <= win_id_d;
                        rom_addr_q <= win_addr_d;
                        cnt_q      <= CNT_W'(ROM_LAT - 1);
                        busy_q     <= 1'b1;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        rd_data_q <= rom_data;
                        ack_q     <= ack_onehot_d;
                        state_q   <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ACK: begin
                    // Requests are not looked at here; the next grant waits for IDLE.
                    ack_q    <= '0;
                    busy_q   <= 1'b0;
`ifndef I4001_ARB_FIXED_PRI_EN
                    rr_ptr_q <= rr_next_d;
`endif
                    state_q  <= ST_IDLE;
                end
                default: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign rd_data  = rd_data_q;
    assign rom_addr = rom_addr_q;
    assign busy     = busy_q;
    assign gnt_id   = gnt_id_q;

endmodule

// File: tb/tb_i4001_rom_arbiter.sv
// Self-checking bench for i4001_rom_arbiter: vector table, scoreboard queue and multi-cycle corner sequences.
// The ROM model answers combinationally from the registered rom_addr, i.e. a one-cycle store.
module tb_i4001_rom_arbiter;

    localparam int N_REQ   = 2;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int ROM_LAT = 1;
    localparam int IDW     = 3;

    logic                    sysclk = 1'b0;
    logic                    poc;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rd_data;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_data;
    logic                    busy;
    logic [IDW-1:0]          gnt_id;

    i4001_rom_arbiter #(
        .N_REQ  (N_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ROM_LAT(ROM_LAT),
        .IDW    (IDW)
    ) dut (
        .sysclk  (sysclk),
        .poc     (poc),
        .req     (req),
        .req_addr(req_addr),
        .ack     (ack),
        .rd_data (rd_data),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .busy    (busy),
        .gnt_id  (gnt_id)
    );

    always #5 sysclk = ~sysclk;

    // ROM contents: f(0x0A5) = 0x3C.
    function automatic logic [7:0] rom_f(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h99;
    endfunction

    assign rom_data = rom_f(rom_addr);

    typedef struct {
        logic [1:0] ack;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  req;
        logic [11:0] a0;
        logic [11:0] a1;
        int          gnt;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic set_addr(input logic [11:0] a0, input logic [11:0] a1);
        req_addr = {a1, a0};
    endtask

    task automatic push(input logic [1:0] a, input logic [7:0] d);
        exp_t e;
        e.ack  = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Waits (bounded) for an ack pulse, checks its latency in negedges and pops the scoreboard.
    task automatic wait_ack(input string name, input int exp_c);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (ack !== 2'b00) begin
                seen = 1'b1;
                check({name, ".lat"}, 32'(c), 32'(exp_c));
                if (sb_q.size() == 0) begin
                    check({name, ".unexpected_ack"}, 32'(ack), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({name, ".ack"}, 32'(ack), 32'(e.ack));
                    check({name, ".rd_data"}, 32'(rd_data), 32'(e.data));
                end
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout: got no ack, expected one within 12 cycles", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_g;
        logic [11:0] exp_a;

        // Reset held with both requests asserted.
        poc = 1'b1;
        req = 2'b11;
        set_addr(12'h0A5, 12'h123);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst%0d.ack", i), 32'(ack), 32'd0);
            check($sformatf("rst%0d.busy", i), 32'(busy), 32'd0);
            check($sformatf("rst%0d.rom_addr", i), 32'(rom_addr), 32'd0);
            check($sformatf("rst%0d.rd_data", i), 32'(rd_data), 32'd0);
        end
        req = 2'b00;
        poc = 1'b0;
        tick();
        check("idle.busy", 32'(busy), 32'd0);
        check("idle.gnt_id", 32'(gnt_id), 32'd0);

        // Single transactions; expected winner follows the rotation from rr_ptr=0.
        vecs[0] = '{2'b01, 12'h0A5, 12'h000, 0};
        vecs[1] = '{2'b11, 12'h010, 12'h020, 1};
        vecs[2] = '{2'b11, 12'h010, 12'h020, 0};
        vecs[3] = '{2'b01, 12'h0A5, 12'h123, 0};
        vecs[4] = '{2'b10, 12'h000, 12'hFFF, 1};
        vecs[5] = '{2'b10, 12'h000, 12'h456, 1};
        vecs[6] = '{2'b11, 12'h7FF, 12'h801, 0};
        vecs[7] = '{2'b11, 12'h111, 12'h222, 1};
        for (int v = 0; v < 8; v++) begin
`ifdef I4001_ARB_FIXED_PRI_EN
            exp_g = vecs[v].req[0] ? 0 : 1;
`else
            exp_g = vecs[v].gnt;
`endif
            exp_a = (exp_g == 1) ? vecs[v].a1 : vecs[v].a0;
            set_addr(vecs[v].a0, vecs[v].a1);
            req = vecs[v].req;
            push((exp_g == 1) ? 2'b10 : 2'b01, rom_f(exp_a));
            tick();
            check($sformatf("v%0d.busy", v), 32'(busy), 32'd1);
            check($sformatf("v%0d.gnt_id", v), 32'(gnt_id), 32'(exp_g));
            check($sformatf("v%0d.rom_addr", v), 32'(rom_addr), 32'(exp_a));
            wait_ack($sformatf("v%0d", v), 0);
            req = 2'b00;
            tick();
            check($sformatf("v%0d.ack_off", v), 32'(ack), 32'd0);
            check($sformatf("v%0d.busy_off", v), 32'(busy), 32'd0);
            check($sformatf("v%0d.rd_hold", v), 32'(rd_data), 32'(rom_f(exp_a)));
        end

        // Both requests held from a fresh reset.
        poc = 1'b1;
        tick();
        tick();
        poc = 1'b0;
        set_addr(12'h010, 12'h020);
`ifdef I4001_ARB_FIXED_PRI_EN
        push(2'b01, 8'h89);
        push(2'b01, 8'h89);
        push(2'b01, 8'h89);
        req = 2'b11;
        wait_ack("fp0", 1);
        wait_ack("fp1", 2);
        wait_ack("fp2", 2);
        req = 2'b10;
        push(2'b10, 8'hB9);
        wait_ack("fp3", 2);
`else
        push(2'b01, 8'h89);
        push(2'b10, 8'hB9);
        push(2'b01, 8'h89);
        push(2'b10, 8'hB9);
        req = 2'b11;
        wait_ack("cont0", 1);
        wait_ack("cont1", 2);
        wait_ack("cont2", 2);
        wait_ack("cont3", 2);
`endif
        req = 2'b00;
        tick();
        check("cont.busy_off", 32'(busy), 32'd0);

        // Address changes after grant must not affect the transaction.
        set_addr(12'h000, 12'h123);
        push(2'b10, 8'hAB);
        req = 2'b10;
        tick();
        check("chg.gnt_id", 32'(gnt_id), 32'd1);
        set_addr(12'h000, 12'h456);
        wait_ack("chg", 0);
        check("chg.rom_addr", 32'(rom_addr), 32'h123);
        req = 2'b00;
        tick();

        // Abort mid-transaction with rr_ptr pointing at requester 1.
        set_addr(12'h0A5, 12'h000);
        push(2'b01, 8'h3C);
        req = 2'b01;
        wait_ack("pre_abort", 1);
        req = 2'b00;
        tick();
        set_addr(12'h0A5, 12'h456);
        req = 2'b10;
        tick();
        check("abort.busy_wait", 32'(busy), 32'd1);
        poc = 1'b1;
        req = 2'b00;
        tick();
        check("abort.ack", 32'(ack), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.gnt_id", 32'(gnt_id), 32'd0);
        check("abort.rom_addr", 32'(rom_addr), 32'd0);
        check("abort.rd_data", 32'(rd_data), 32'd0);
        poc = 1'b0;
        tick();
        check("abort.ack_after", 32'(ack), 32'd0);
        check("abort.busy_after", 32'(busy), 32'd0);
        set_addr(12'h010, 12'h020);
        push(2'b01, 8'h89);
        req = 2'b11;
        wait_ack("post_abort0", 1);
        req = 2'b10;
        push(2'b10, 8'hB9);
        wait_ack("post_abort1", 2);
        req = 2'b00;
        tick();
        check("end.busy", 32'(busy), 32'd0);
        check("end.ack", 32'(ack), 32'd0);
        check("end.sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
